// File: rtl/pll_lock_seq.sv
// pll_lock_seq: reset and lock sequencer for a cascaded two-PLL clock tree.
// PLL1 is brought out of reset first. PLL2, which is referenced to PLL1's
// output, is released only after PLL1 has held lock for a qualified period.
// When both PLLs are qualified, the block releases the downstream domain
// reset and raises clk_rdy. A loss of lock restarts the affected stage.
// Repeated lock timeouts latch a sticky fault.
//
// Optional feature (compile-time macro PLL_LOCK_SYNC_EN):
//   defined   - locked1/locked2 each pass through a 2-flop synchronizer
//               (reset to 0), which adds 2 cycles of input latency
//   undefined - locked1/locked2 are used directly
//
// Ports:
//   sys_clk     in   board reference clock, the only clock of the block
//   rst         in   synchronous active-high reset
//   locked1     in   PLL1 lock indicator (asynchronous)
//   locked2     in   PLL2 lock indicator (asynchronous)
//   pll1_areset out  PLL1 reset, active-high
//   pll2_areset out  PLL2 reset, active-high
//   dom_rst     out  downstream domain reset, active-high
//   clk_rdy     out  both PLLs qualified locked
//   fault       out  sticky lock failure
//   retry_cnt   out  [7:0] timeouts since the last entry to RUN
//   state       out  [2:0] current state, for debug
module pll_lock_seq #(
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       locked1,
  input  logic       locked2,
  output logic       pll1_areset,
  output logic       pll2_areset,
  output logic       dom_rst,
  output logic       clk_rdy,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD) + 1;
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE) + 1;
  localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [2:0] ST_RST1  = 3'd0;
  localparam logic [2:0] ST_WAIT1 = 3'd1;
  localparam logic [2:0] ST_RST2  = 3'd2;
  localparam logic [2:0] ST_WAIT2 = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  logic              l1;
  logic              l2;
  logic [2:0]        state_nxt;
  logic [7:0]        retry_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [STAB_W-1:0] stab_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              l_sel;
  logic              hold_done;
  logic              stab_done;
  logic              tmo_done;

  // Lock input conditioning
`ifdef PLL_LOCK_SYNC_EN
  logic [1:0] sync1;
  logic [1:0] sync2;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {sync1[0], locked1};
      sync2 <= {sync2[0], locked2};
    end
  end

  assign l1 = sync1[1];
  assign l2 = sync2[1];
`else
  assign l1 = locked1;
  assign l2 = locked2;
`endif

  // States whose time counts toward the lock timeout
  function automatic logic is_timed(input logic [2:0] s);
    return (s == ST_WAIT1) || (s == ST_RST2) || (s == ST_WAIT2);
  endfunction

  // WAIT2 qualifies PLL2; every other state watches PLL1
  assign l_sel     = (state == ST_WAIT2) ? l2 : l1;
  assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD - 1));
  assign stab_done = l_sel && (stab_cnt == STAB_W'(LOCK_STABLE - 1));
  assign tmo_done  = is_timed(state) && (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));

  // Next-state logic; within a timed state: PLL1 loss, then timeout, then progress
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      ST_RST1: begin
        if (hold_done) state_nxt = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (tmo_done) begin
          if (retry_cnt == 8'(MAX_RETRY)) begin
            state_nxt = ST_FAULT;
          end else begin
            state_nxt = ST_RST1;
            retry_nxt = retry_cnt + 8'd1;
          end
        end else if (stab_done) begin
          state_nxt = ST_RST2;
        end
      end
      ST_RST2, ST_WAIT2: begin
        if (!l1) begin
          state_nxt = ST_RST1;
        end else if (tmo_done) begin
          if (retry_cnt == 8'(MAX_RETRY)) begin
            state_nxt = ST_FAULT;
          end else begin
            state_nxt = ST_RST1;
            retry_nxt = retry_cnt + 8'd1;
          end
        end else if ((state == ST_RST2) && hold_done) begin
          state_nxt = ST_WAIT2;
        end else if ((state == ST_WAIT2) && stab_done) begin
          state_nxt = ST_RUN;
          retry_nxt = 8'd0;
        end
      end
      ST_RUN: begin
        if (!l1) begin
          state_nxt = ST_RST1;
        end else if (!l2) begin
          state_nxt = ST_RST2;
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_RST1;
      end
    endcase
  end

  // State, counters and outputs; outputs decode the next state so they
  // change on the same edge as the state register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= ST_RST1;
      retry_cnt   <= 8'd0;
      hold_cnt    <= '0;
      stab_cnt    <= '0;
      tmo_cnt     <= '0;
      pll1_areset <= 1'b1;
      pll2_areset <= 1'b1;
      dom_rst     <= 1'b1;
      clk_rdy     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;

      if ((state_nxt == state) && ((state == ST_RST1) || (state == ST_RST2))) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end

      if ((state_nxt == state) && l_sel &&
          ((state == ST_WAIT1) || (state == ST_WAIT2))) begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end else begin
        stab_cnt <= '0;
      end

      // Accumulates across WAIT1/RST2/WAIT2; cleared whenever the path leaves them
      if (is_timed(state) && is_timed(state_nxt)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end

      pll1_areset <= (state_nxt == ST_RST1) || (state_nxt == ST_FAULT);
      pll2_areset <= (state_nxt == ST_RST1) || (state_nxt == ST_WAIT1) ||
                     (state_nxt == ST_RST2) || (state_nxt == ST_FAULT);
      dom_rst     <= (state_nxt != ST_RUN);
      clk_rdy     <= (state_nxt == ST_RUN);
      fault       <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: self-checking bench for pll_lock_seq (macro PLL_LOCK_SYNC_EN
// undefined). A phase/age/run-length reference model predicts every output
// after each clock edge; scenario tasks add fixed-cycle checks.
module tb_pll_lock_seq;

  localparam int RST_HOLD     = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int MAX_RETRY    = 2;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       locked1;
  logic       locked2;
  logic       pll1_areset;
  logic       pll2_areset;
  logic       dom_rst;
  logic       clk_rdy;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  always #5 sys_clk = ~sys_clk;

  pll_lock_seq #(
    .RST_HOLD    (RST_HOLD),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .locked1    (locked1),
    .locked2    (locked2),
    .pll1_areset(pll1_areset),
    .pll2_areset(pll2_areset),
    .dom_rst    (dom_rst),
    .clk_rdy    (clk_rdy),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  int n_chk;
  int n_pass;

  // Reference model: phase number, edges spent in the phase, raw run lengths
  // of each lock input, time accumulated in the timed phases, retries.
  int m_phase;
  int m_age;
  int m_run1;
  int m_run2;
  int m_wait;
  int m_retry;

  localparam logic [15:0] RESET_VEC = {3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  function automatic logic [15:0] obs_vec();
    return {state, retry_cnt, fault, clk_rdy, dom_rst, pll2_areset, pll1_areset};
  endfunction

  function automatic logic [15:0] model_vec();
    logic p1, p2;
    p1 = (m_phase == 0) || (m_phase == 5);
    p2 = (m_phase <= 2) || (m_phase == 5);
    return {3'(m_phase), 8'(m_retry), (m_phase == 5), (m_phase == 4),
            (m_phase != 4), p2, p1};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_run1  = 0;
    m_run2  = 0;
    m_wait  = 0;
    m_retry = 0;
  endtask

  task automatic model_step(input logic a, input logic b);
    int  p, np, r1, r2;
    bit  timed, tmo, q1, q2, hold_done;
    p      = m_phase;
    np     = p;
    m_run1 = a ? m_run1 + 1 : 0;
    m_run2 = b ? m_run2 + 1 : 0;
    // only highs seen since the phase began count toward qualification
    r1 = (m_run1 < m_age + 1) ? m_run1 : m_age + 1;
    r2 = (m_run2 < m_age + 1) ? m_run2 : m_age + 1;
    q1 = (r1 >= LOCK_STABLE);
    q2 = (r2 >= LOCK_STABLE);
    timed     = (p >= 1) && (p <= 3);
    tmo       = timed && (m_wait + 1 >= LOCK_TIMEOUT);
    hold_done = (m_age + 1 >= RST_HOLD);
    case (p)
      0: if (hold_done) np = 1;
      1: if (tmo) np = -1; else if (q1) np = 2;
      2: if (!a) np = 0; else if (tmo) np = -1; else if (hold_done) np = 3;
      3: begin
        if (!a) np = 0;
        else if (tmo) np = -1;
        else if (q2) begin np = 4; m_retry = 0; end
      end
      4: if (!a) np = 0; else if (!b) np = 2;
      default: np = p;
    endcase
    if (np == -1) begin
      if (m_retry == MAX_RETRY) np = 5;
      else begin np = 0; m_retry = m_retry + 1; end
    end
    m_age = (np != p) ? 0 : m_age + 1;
    if (np == 0 || np == 4) m_wait = 0;
    else if (timed) m_wait = m_wait + 1;
    m_phase = np;
  endtask

  // Drive inputs, clock one edge, advance model, return at the falling edge
  task automatic tick(input logic a, input logic b);
    locked1 = a;
    locked2 = b;
    @(posedge sys_clk);
    model_step(a, b);
    @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    locked1 = 1'b0;
    locked2 = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    model_reset();
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (obs_vec() !== RESET_VEC)
      $display("FAIL reset_values: got %h expected %h", obs_vec(), RESET_VEC);
    else n_pass++;
  endtask

  // Clean bring-up from the current (just reset) state
  task automatic run_bringup(input string tag);
    for (int k = 0; k < 30; k++) begin
      tick(k >= 4, k >= 18);
      n_chk++;
      if (obs_vec() !== model_vec())
        $display("FAIL %s_model tick %0d: got %h expected %h", tag, k, obs_vec(), model_vec());
      else n_pass++;
      if (k == 2 || k == 3) begin
        n_chk++;
        if (pll1_areset !== (k == 2))
          $display("FAIL %s_pll1_release tick %0d: got %b expected %b", tag, k, pll1_areset, k == 2);
        else n_pass++;
      end
      if (k == 14 || k == 15) begin
        n_chk++;
        if (pll2_areset !== (k == 14))
          $display("FAIL %s_pll2_release tick %0d: got %b expected %b", tag, k, pll2_areset, k == 14);
        else n_pass++;
      end
      if (k == 24 || k == 25) begin
        n_chk++;
        if ({state, clk_rdy, dom_rst, retry_cnt} !==
            ((k == 25) ? {3'd4, 1'b1, 1'b0, 8'd0} : {3'd3, 1'b0, 1'b1, 8'd0}))
          $display("FAIL %s_run_entry tick %0d: got state=%0d rdy=%b dom=%b retry=%0d",
                   tag, k, state, clk_rdy, dom_rst, retry_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bringup();
    apply_reset();
    run_bringup("bringup");
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      tick((k >= 4) && (k != 11), 1'b0);
      n_chk++;
      if (obs_vec() !== model_vec())
        $display("FAIL glitch_model tick %0d: got %h expected %h", k, obs_vec(), model_vec());
      else n_pass++;
      if (k == 18 || k == 19) begin
        n_chk++;
        if (state !== ((k == 19) ? 3'd2 : 3'd1))
          $display("FAIL glitch_exit tick %0d: got state %0d expected %0d", k, state, (k == 19) ? 2 : 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pll2_loss();
    apply_reset();
    for (int k = 0; k < 30; k++) tick(k >= 4, k >= 18);
    tick(1'b1, 1'b0);
    n_chk++;
    if ({state, clk_rdy, dom_rst, pll2_areset, pll1_areset} !== {3'd2, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL pll2_loss_resp: got state=%0d rdy=%b dom=%b a2=%b a1=%b expected 2 0 1 1 0",
               state, clk_rdy, dom_rst, pll2_areset, pll1_areset);
    else n_pass++;
    for (int k = 1; k <= 13; k++) begin
      tick(1'b1, 1'b1);
      if (k <= 4) begin
        n_chk++;
        if ({pll2_areset, pll1_areset} !== {(k < 4), 1'b0})
          $display("FAIL pll2_loss_hold step %0d: got a2=%b a1=%b expected a2=%b a1=0",
                   k, pll2_areset, pll1_areset, k < 4);
        else n_pass++;
      end
      n_chk++;
      if (obs_vec() !== model_vec())
        $display("FAIL pll2_loss_model step %0d: got %h expected %h", k, obs_vec(), model_vec());
      else n_pass++;
    end
    n_chk++;
    if (state !== 3'd4)
      $display("FAIL pll2_loss_rerun: got state %0d expected 4", state);
    else n_pass++;
  endtask

  task automatic test_pll1_loss();
    logic [1:0] drop [2];
    drop[0] = 2'b01;
    drop[1] = 2'b00;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 30; k++) tick(1'b1, 1'b1);
      n_chk++;
      if (state !== 3'd4)
        $display("FAIL pll1_loss_pre case %0d: got state %0d expected 4", c, state);
      else n_pass++;
      tick(drop[c][1], drop[c][0]);
      n_chk++;
      if ({state, pll1_areset, pll2_areset, clk_rdy, dom_rst} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b1})
        $display("FAIL pll1_loss_resp case %0d: got state=%0d a1=%b a2=%b rdy=%b dom=%b",
                 c, state, pll1_areset, pll2_areset, clk_rdy, dom_rst);
      else n_pass++;
      n_chk++;
      if (obs_vec() !== model_vec())
        $display("FAIL pll1_loss_model case %0d: got %h expected %h", c, obs_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_timeout_fault();
    apply_reset();
    for (int k = 0; k < 120; k++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      n_chk++;
      if (obs_vec() !== model_vec())
        $display("FAIL timeout_model tick %0d: got %h expected %h", k, obs_vec(), model_vec());
      else n_pass++;
      if (k == 34 || k == 35 || k == 71 || k == 106 || k == 107) begin
        logic [11:0] want;
        case (k)
          34:      want = {3'd1, 8'd0, 1'b0};
          35:      want = {3'd0, 8'd1, 1'b0};
          71:      want = {3'd0, 8'd2, 1'b0};
          106:     want = {3'd1, 8'd2, 1'b0};
          default: want = {3'd5, 8'd2, 1'b1};
        endcase
        n_chk++;
        if ({state, retry_cnt, fault} !== want)
          $display("FAIL timeout_seq tick %0d: got state=%0d retry=%0d fault=%b expected %h",
                   k, state, retry_cnt, fault, want);
        else n_pass++;
      end
    end
    n_chk++;
    if ({state, fault} !== {3'd5, 1'b1})
      $display("FAIL fault_sticky: got state=%0d fault=%b expected 5 1", state, fault);
    else n_pass++;
    apply_reset();
    n_chk++;
    if ({state, fault, retry_cnt} !== {3'd0, 1'b0, 8'd0})
      $display("FAIL fault_clear: got state=%0d fault=%b retry=%0d expected 0 0 0", state, fault, retry_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int k = 0; k < 20; k++) tick(k >= 4, k >= 18);
    n_chk++;
    if (state !== 3'd3)
      $display("FAIL mid_reset_pre: got state %0d expected 3", state);
    else n_pass++;
    rst     = 1'b1;
    locked1 = 1'b0;
    locked2 = 1'b0;
    @(posedge sys_clk);
    model_reset();
    @(negedge sys_clk);
    rst = 1'b0;
    n_chk++;
    if (obs_vec() !== RESET_VEC)
      $display("FAIL mid_reset_values: got %h expected %h", obs_vec(), RESET_VEC);
    else n_pass++;
    run_bringup("rebringup");
  endtask

  task automatic test_random();
    logic r1, r2;
    for (int t = 0; t < 6; t++) begin
      apply_reset();
      r1 = 1'b0;
      r2 = 1'b0;
      for (int k = 0; k < 600; k++) begin
        if (r1) r1 = ($urandom_range(0, 99) >= 2);
        else    r1 = ($urandom_range(0, 99) < 25);
        if (r2) r2 = ($urandom_range(0, 99) >= 3);
        else    r2 = ($urandom_range(0, 99) < 25);
        if ($urandom_range(0, 499) == 0) begin
          rst     = 1'b1;
          locked1 = r1;
          locked2 = r2;
          @(posedge sys_clk);
          model_reset();
          @(negedge sys_clk);
          rst = 1'b0;
        end else begin
          tick(r1, r2);
        end
        n_chk++;
        if (obs_vec() !== model_vec())
          $display("FAIL random_model trial %0d tick %0d: got %h expected %h",
                   t, k, obs_vec(), model_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    locked1 = 1'b0;
    locked2 = 1'b0;
    model_reset();
    @(negedge sys_clk);
    test_reset();
    test_bringup();
    test_glitch();
    test_pll2_loss();
    test_pll1_loss();
    test_timeout_fault();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
